microcode_sequencer: RTL

//  Parametrised, stateful successor to the fixed microcode ROM. Owns the micro-step counter,

---
 rtl/microcode_sequencer_pkg.sv | 60 ++++++
 rtl/microcode_sequencer_ucode_store.sv | 58 +++++
 rtl/microcode_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/microcode_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: FSM states, default opcodes and the default control store.
// Purely combinational helpers. There is no timing or flow control here.
// Entries are {END, cw}. The fetch rows come first, then each opcode's EXEC rows from step FETCH_STEPS.
package microcode_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    localparam logic [7:0] OP_LDA = 8'd0;
    localparam logic [7:0] OP_LDB = 8'd1;
    localparam logic [7:0] OP_ADD = 8'd2;

    localparam int DEF_CW_W  = 32;
    localparam int END_BIT_D = DEF_CW_W;

    localparam logic [31:0] FETCH_CW0 = 32'h0040880A;
    localparam logic [31:0] FETCH_CW1 = 32'h0040430A;
    localparam logic [31:0] FETCH_CW2 = 32'h0044410A;
    localparam logic [31:0] FETCH_CW3 = 32'h004A800A;
    localparam logic [31:0] LDA_CW0   = 32'h0040410A;
    localparam logic [31:0] LDA_CW1   = 32'h4040414A;
    localparam logic [31:0] LDB_CW0   = 32'h0440410A;
    localparam logic [31:0] LDB_CW1   = 32'h0440414A;
    localparam logic [31:0] ADD_CW0   = 32'h8840004A;

    // Default program lookup. The op argument is ignored for fetch rows.
    function automatic logic [32:0] default_entry(input int op, input int step, input int fetch_steps);
        logic [32:0] e;
        e = '0;
        if (step < fetch_steps) begin
            case (step)
                0:       e = {1'b0, FETCH_CW0};
                1:       e = {1'b0, FETCH_CW1};
                2:       e = {1'b0, FETCH_CW2};
                3:       e = {1'b0, FETCH_CW3};
                default: e = '0;
            endcase
        end else begin
            case (op)
                int'(OP_LDA): begin
                    if (step - fetch_steps == 0)      e = {1'b0, LDA_CW0};
                    else if (step - fetch_steps == 1) e = {1'b1, LDA_CW1};
                end
                int'(OP_LDB): begin
                    if (step - fetch_steps == 0)      e = {1'b0, LDB_CW0};
                    else if (step - fetch_steps == 1) e = {1'b1, LDB_CW1};
                end
                int'(OP_ADD): begin
                    if (step - fetch_steps == 0)      e = {1'b1, ADD_CW0};
                end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/microcode_sequencer_ucode_store.sv
// Control store: constant default program, or a writable overlay when UCODE_WRITE_EN is defined.
// Latency: combinational read. A write lands at the clock edge, so a same-cycle read returns the old entry.
// Backpressure: none. Writes are accepted every cycle.
module ucode_store
    import microcode_sequencer_pkg::*;
#(
    parameter int CW_W        = 32,
    parameter int OP_W        = 8,
    parameter int STEP_W      = 8,
    parameter int FETCH_STEPS = 4
) (
`ifdef UCODE_WRITE_EN
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [OP_W+STEP_W-1:0] wr_addr,
    input  logic [CW_W:0]          wr_data,
`endif
    input  logic [OP_W+STEP_W-1:0] rd_addr,
    output logic [CW_W:0]          rd_data
);

    localparam int AW    = OP_W + STEP_W;
    localparam int DEPTH = 2 ** AW;

    logic [32:0]   def_raw;
    logic [CW_W:0] def_entry;

    always_comb begin
        def_raw   = default_entry(int'(rd_addr[AW-1:STEP_W]), int'(rd_addr[STEP_W-1:0]), FETCH_STEPS);
        def_entry = {def_raw[32], CW_W'(def_raw[31:0])};
    end

`ifdef UCODE_WRITE_EN
    logic [CW_W:0]    mem [DEPTH];
    logic [DEPTH-1:0] written;

    // A per-entry written flag lets reset restore the default program without clearing the whole array.
    always_ff @(posedge clk) begin
        if (rst) begin
            written <= '0;
        end else if (wr_en) begin
            written[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = written[rd_addr] ? mem[rd_addr] : def_entry;
`else
    assign rd_data = def_entry;
`endif

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer with step counter, opcode latch, fetch/dispatch, END detection, stall and halt. Optional UCODE_WRITE_EN.
// Latency: the first EXEC word appears 1 cycle after the last fetch step. All outputs are registered from the next {state,op,step}.
// Backpressure: stall_in holds every register and forces illegal_op low.
module microcode_sequencer
    import microcode_sequencer_pkg::*;
#(
    parameter int              CW_W        = 32,
    parameter int              OP_W        = 8,
    parameter int              STEP_W      = 8,
    parameter int              FETCH_STEPS = 4,
    parameter int              NUM_OPS     = 3,
    parameter logic [OP_W-1:0] HALT_OP     = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_W-1:0]        opcode_in,
    input  logic                   stall_in,
`ifdef UCODE_WRITE_EN
    input  logic                   wr_en,
    input  logic [OP_W+STEP_W-1:0] wr_addr,
    input  logic [CW_W:0]          wr_data,
`endif
    output logic [CW_W-1:0]        ctrl_word_out,
    output logic [STEP_W-1:0]      step_out,
    output logic                   instr_done,
    output logic                   illegal_op,
    output logic                   halted
);

    seq_state_t             state_q, state_n;
    logic [STEP_W-1:0]      step_q, step_n;
    logic [OP_W-1:0]        op_q, op_n;
    logic                   ill_n;
    logic [OP_W+STEP_W-1:0] rd_addr;
    logic [CW_W:0]          rd_data;

    always_comb begin
        state_n = state_q;
        step_n  = step_q;
        op_n    = op_q;
        ill_n   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (step_q == STEP_W'(FETCH_STEPS - 1)) begin
                    op_n = opcode_in;
                    if (int'(opcode_in) < NUM_OPS) begin
                        state_n = ST_EXEC;
                        step_n  = STEP_W'(FETCH_STEPS);
                    end else if (opcode_in == HALT_OP) begin
                        state_n = ST_HALTED;
                    end else begin
                        step_n = '0;
                        ill_n  = 1'b1;
                    end
                end else begin
                    step_n = step_q + 1'b1;
                end
            end
            ST_EXEC: begin
                // instr_done already holds the END bit of the step on display.
                // Running off the top of the counter falls back to fetch instead of wrapping.
                if (instr_done || (step_q == '1)) begin
                    state_n = ST_FETCH;
                    step_n  = '0;
                end else begin
                    step_n = step_q + 1'b1;
                end
            end
            ST_HALTED: ;
            default: begin
                state_n = ST_FETCH;
                step_n  = '0;
            end
        endcase
    end

    assign rd_addr = (state_n == ST_FETCH) ? {{OP_W{1'b0}}, step_n} : {op_n, step_n};

    ucode_store #(
        .CW_W        (CW_W),
        .OP_W        (OP_W),
        .STEP_W      (STEP_W),
        .FETCH_STEPS (FETCH_STEPS)
    ) u_store (
`ifdef UCODE_WRITE_EN
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            step_q        <= '0;
            op_q          <= '0;
            ctrl_word_out <= CW_W'(FETCH_CW0);
            instr_done    <= 1'b0;
            illegal_op    <= 1'b0;
            halted        <= 1'b0;
        end else if (stall_in) begin
            illegal_op <= 1'b0;
        end else begin
            state_q       <= state_n;
            step_q        <= step_n;
            op_q          <= op_n;
            ctrl_word_out <= (state_n == ST_HALTED) ? '0 : rd_data[CW_W-1:0];
            instr_done    <= (state_n == ST_EXEC) && rd_data[CW_W];
            illegal_op    <= ill_n;
            halted        <= (state_n == ST_HALTED);
        end
    end

    assign step_out = step_q;

endmodule
